cdc_handshake_tx: RTL and testbench

Launch-side controller for multi-bit clock-domain crossings in the AXI USB slave. It accepts a word from local logic, holds it stable on the crossing bus, and runs a 4-phase req/ack handshake with the remote domain. The remote side samples the bus only after its synchronized `xfer_req` rises. The block guarantees the bus never changes while the remote side may be sampling it, and it flags transfers the remote never acknowledges.

---
 rtl/cdc_hs_pkg.sv | 17 +
 rtl/cdc_sync_bit.sv | 28 ++
 rtl/cdc_handshake_tx.sv | 161 ++++++++++++++++
 tb/tb_cdc_handshake_tx.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_hs_pkg.sv
// Shared types and constants for the launch side of the req/ack clock-domain crossing.
package cdc_hs_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } cdc_hs_state_t;

    localparam int XFER_CNT_W = 16;

    // A timeout of 0 disables the timer, but the register still needs at least one bit.
    function automatic int tmr_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Destination-side multi-flop synchronizer for a single level signal.
// Resets to 0 so that a remote level which is still high after reset only
// becomes visible once it has passed through every stage.
module cdc_sync_bit
    import cdc_hs_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic q_sync
);

    (* preserve, dont_replicate *) logic [SYNC_STAGES-1:0] sync_ff;

    // Shift the asynchronous level through the synchronizer chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], d_async};
        end
    end

    assign q_sync = sync_ff[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Launch-side 4-phase req/ack controller for a multi-bit crossing bus.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | bus free; accepts a word once the synchronized ack is low
//   REQ     | xfer_req high, bus frozen, waiting for ack (or timeout)
//   RELEASE | xfer_req low, waiting for the remote to drop ack
//
// The bus only ever changes on an IDLE acceptance, and acceptance needs the
// synchronized ack low, so the remote can never be sampling a moving bus.
module cdc_handshake_tx
    import cdc_hs_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WIDTH-1:0]      s_data,
    output logic [WIDTH-1:0]      xfer_data,
    output logic                  xfer_req,
    input  logic                  ack_async,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic                  err_clr,
    output logic [XFER_CNT_W-1:0] xfer_count
);

    localparam int                    TMR_W       = tmr_width(TIMEOUT);
    localparam bit                    TMO_EN      = (TIMEOUT > 0);
    // Down-counter loaded on acceptance; terminal count 0 marks the last REQ cycle.
    localparam logic [TMR_W-1:0]      TMR_LOAD    = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam int                    SETTLE_W    = $clog2(SYNC_STAGES + 1);
    localparam logic [SETTLE_W-1:0]   SETTLE_LOAD = SETTLE_W'(SYNC_STAGES);

    cdc_hs_state_t         state_q;
    cdc_hs_state_t         state_d;
    logic                  ack_sync;
    logic [TMR_W-1:0]      tmr_q;
    logic [SETTLE_W-1:0]   settle_q;
    logic                  timed_out_q;
    logic                  accept;
    logic                  timeout_hit;
    logic                  ack_seen;
    logic                  finish;

    cdc_sync_bit #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk     (clk),
        .rst     (rst),
        .d_async (ack_async),
        .q_sync  (ack_sync)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = REQ;
            REQ:     if (ack_seen || timeout_hit) state_d = RELEASE;
            RELEASE: if (!ack_sync) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake strobes and status outputs.
    // Ready also waits for the synchronizer to refill after reset: its stages
    // reset to 0, so a remote ack still high from an interrupted handshake
    // would otherwise look low for SYNC_STAGES cycles.
    always_comb begin
        s_ready     = (state_q == IDLE) && !ack_sync && (settle_q == '0);
        busy        = (state_q != IDLE);
        accept      = s_ready && s_valid;
        ack_seen    = (state_q == REQ) && ack_sync;
        timeout_hit = TMO_EN && (state_q == REQ) && !ack_sync && (tmr_q == '0);
        finish      = (state_q == RELEASE) && !ack_sync;
    end

    // Post-reset settle counter: counts down SYNC_STAGES cycles then holds at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_q <= SETTLE_LOAD;
        end else if (settle_q != '0) begin
            settle_q <= settle_q - 1'b1;
        end
    end

    // REQ timer: load on acceptance, count down while waiting, saturate at terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr_q <= '0;
        end else if (accept) begin
            tmr_q <= TMR_LOAD;
        end else if ((state_q == REQ) && (tmr_q != '0)) begin
            tmr_q <= tmr_q - 1'b1;
        end
    end

    // Crossing bus and request level; the bus is written only on acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_data <= '0;
            xfer_req  <= 1'b0;
        end else begin
            if (accept) begin
                xfer_data <= s_data;
                xfer_req  <= 1'b1;
            end else if (ack_seen || timeout_hit) begin
                xfer_req  <= 1'b0;
            end
        end
    end

    // Sticky timeout flag (set beats clear) and per-handshake timeout marker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err         <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            if (timeout_hit) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
            if (accept) begin
                timed_out_q <= 1'b0;
            end else if (timeout_hit) begin
                timed_out_q <= 1'b1;
            end
        end
    end

    // Completion pulse and wrapping transfer counter for acknowledged handshakes only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done       <= 1'b0;
            xfer_count <= '0;
        end else begin
            done <= 1'b0;
            if (finish && !timed_out_q) begin
                done       <= 1'b1;
                xfer_count <= xfer_count + XFER_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx (WIDTH=8, SYNC_STAGES=2, TIMEOUT=16).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_cdc_handshake_tx;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic [7:0]  xfer_data;
    logic        xfer_req;
    logic        ack_async;
    logic        busy;
    logic        done;
    logic        err;
    logic        err_clr;
    logic [15:0] xfer_count;

    int errors = 0;
    int checks = 0;

    cdc_handshake_tx #(
        .WIDTH       (8),
        .SYNC_STAGES (2),
        .TIMEOUT     (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .xfer_data  (xfer_data),
        .xfer_req   (xfer_req),
        .ack_async  (ack_async),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_clr    (err_clr),
        .xfer_count (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Remote model that mirrors xfer_req onto ack until a done pulse (bounded).
    task automatic finish_xfer(output logic saw);
        saw = 1'b0;
        for (int n = 0; n < 40 && !saw; n++) begin
            ack_async = xfer_req;
            tick();
            if (done) saw = 1'b1;
        end
        ack_async = xfer_req;
    endtask

    logic       acc;
    logic       hold;
    logic [7:0] pd;
    logic [7:0] idx;
    int         ndone;
    logic       saw;

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; ack_async = 1'b0; err_clr = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_req",   xfer_req,   1'b0);
        chk("rst_data",  xfer_data,  8'h00);
        chk("rst_err",   err,        1'b0);
        chk("rst_done",  done,       1'b0);
        chk("rst_count", xfer_count, 16'h0000);
        chk("rst_busy",  busy,       1'b0);
        rst = 1'b0;
        tick(); tick();
        chk("ready_after_reset", s_ready, 1'b1);

        // Single transfer, remote acks 3 cycles after acceptance
        s_data = 8'hA5; s_valid = 1'b1;
        tick();
        s_valid = 1'b0; s_data = 8'hFF;
        chk("single_req_rise", xfer_req,  1'b1);
        chk("single_data",     xfer_data, 8'hA5);
        chk("single_busy",     busy,      1'b1);
        chk("single_ready",    s_ready,   1'b0);
        tick(); tick();
        chk("single_req_hold", xfer_req, 1'b1);
        tick();
        ack_async = 1'b1;
        tick();
        chk("single_req_sync1", xfer_req, 1'b1);
        tick();
        chk("single_req_sync2", xfer_req, 1'b1);
        tick();
        chk("single_req_drop", xfer_req,  1'b0);
        chk("single_rel_busy", busy,      1'b1);
        chk("single_rel_data", xfer_data, 8'hA5);
        ack_async = 1'b0;
        tick();
        chk("single_rel_data2", xfer_data, 8'hA5);
        chk("single_nodone1",   done,      1'b0);
        tick();
        chk("single_rel_busy2", busy, 1'b1);
        chk("single_nodone2",   done, 1'b0);
        tick();
        chk("single_done",       done,       1'b1);
        chk("single_count",      xfer_count, 16'd1);
        chk("single_idle",       busy,       1'b0);
        chk("single_ready_back", s_ready,    1'b1);
        tick();
        chk("single_done_once", done,       1'b0);
        chk("single_count_hold", xfer_count, 16'd1);

        // Back-to-back: s_valid held, remote mirrors req
        idx = 8'h01; s_data = 8'h01; s_valid = 1'b1; ndone = 0;
        for (int c = 0; c < 120 && ndone < 4; c++) begin
            acc  = s_ready && s_valid;
            hold = xfer_req || ack_async;
            pd   = xfer_data;
            if (acc) chk("b2b_accept_idle", busy, 1'b0);
            tick();
            ack_async = xfer_req;
            if (done) ndone++;
            if (acc) begin
                chk("b2b_data", xfer_data, idx);
                idx = idx + 8'h01;
                if (idx > 8'h04) s_valid = 1'b0;
                else             s_data  = idx;
            end else if (hold) begin
                chk("b2b_stable", xfer_data, pd);
            end
        end
        chk("b2b_done_pulses", ndone,      4);
        chk("b2b_count",       xfer_count, 16'd5);

        // Timeout: remote never acks
        s_data = 8'h3C; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        chk("to_req", xfer_req, 1'b1);
        for (int i = 2; i <= 16; i++) begin
            tick();
            chk("to_wait_req", xfer_req, 1'b1);
            chk("to_wait_err", err,      1'b0);
        end
        tick();
        chk("to_err",  err,      1'b1);
        chk("to_req0", xfer_req, 1'b0);
        chk("to_busy", busy,     1'b1);
        chk("to_done", done,     1'b0);
        tick();
        chk("to_idle",   busy,       1'b0);
        chk("to_nodone", done,       1'b0);
        chk("to_count",  xfer_count, 16'd5);
        chk("to_sticky", err,        1'b1);
        chk("to_data",   xfer_data,  8'h3C);

        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_clr", err, 1'b0);

        // Late ack: rises as the timer expires, so it is absorbed by RELEASE
        s_data = 8'hC3; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        for (int i = 2; i <= 34; i++) begin
            tick();
            if (i == 15) ack_async = 1'b1;
            if (i == 30) ack_async = 1'b0;
            if (i == 17) chk("late_err", err, 1'b1);
            if (i >= 17 && i <= 32) begin
                chk("late_busy",   busy,     1'b1);
                chk("late_nodone", done,     1'b0);
                chk("late_req",    xfer_req, 1'b0);
                chk("late_ready",  s_ready,  1'b0);
            end
            if (i == 33) begin
                chk("late_idle",   busy,       1'b0);
                chk("late_nodone", done,       1'b0);
                chk("late_count",  xfer_count, 16'd5);
            end
        end

        // err_clr against a simultaneous timeout: set wins, clear applies next cycle
        s_data = 8'hE7; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        for (int i = 2; i <= 16; i++) tick();
        chk("clr_pre_err", err, 1'b1);
        err_clr = 1'b1;
        tick();
        chk("clr_vs_set", err, 1'b1);
        tick();
        chk("clr_after", err, 1'b0);
        err_clr = 1'b0;
        tick();
        chk("clr_idle",  busy,       1'b0);
        chk("clr_count", xfer_count, 16'd5);

        // Reset mid-handshake with ack held high
        s_data = 8'h5A; s_valid = 1'b1;
        tick();
        s_valid = 1'b0; ack_async = 1'b1;
        tick();
        chk("mid_pre_req", xfer_req, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_req",   xfer_req,   1'b0);
        chk("mid_rst_busy",  busy,       1'b0);
        chk("mid_rst_data",  xfer_data,  8'h00);
        chk("mid_rst_count", xfer_count, 16'd0);
        tick(); tick();
        rst = 1'b0;
        s_data = 8'h77; s_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("mid_ready_blocked", s_ready, 1'b0);
            chk("mid_no_accept",     busy,    1'b0);
        end
        ack_async = 1'b0;
        tick();
        chk("mid_ready_sync1", s_ready, 1'b0);
        tick();
        chk("mid_ready_open", s_ready, 1'b1);
        tick();
        s_valid = 1'b0;
        chk("mid_accept_busy", busy,      1'b1);
        chk("mid_accept_data", xfer_data, 8'h77);
        finish_xfer(saw);
        chk("mid_done_seen", saw,        1'b1);
        chk("mid_count",     xfer_count, 16'd1);

        // Counter wrap: preload 0xFFFF, next completion gives 0
        force dut.xfer_count = 16'hFFFF;
        #1;
        release dut.xfer_count;
        s_data = 8'h99; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        chk("wrap_busy", busy, 1'b1);
        finish_xfer(saw);
        chk("wrap_done_seen", saw,        1'b1);
        chk("wrap_count",     xfer_count, 16'h0000);
        chk("wrap_data",      xfer_data,  8'h99);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
